// File: rtl/pipeline_pkg.sv
// pipeline_pkg: definitions shared by the decode-side redirect logic and the fetch stage.
//   - opcode constants for the 16-bit ISA
//   - pc_src encodings (pc_src_e)
//   - the canonical NOP used to squash a killed fetch
//   - helpers telling which register fields an opcode reads (load-use detection)
package pipeline_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_BNE  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'd0,
        PCSRC_J   = 2'd1,
        PCSRC_I   = 2'd2,
        PCSRC_RET = 2'd3
    } pc_src_e;

    // ADD R1, R1, R0: architecturally a no-op.
    localparam logic [15:0] NOP_INSTR = {OP_ADD, 3'd1, 3'd1, 3'd0, 3'b000};

    // Field [11:9] is a source only for the compare-and-branch opcodes.
    function automatic logic op_reads_rd(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    // Field [8:6] is a source for branches, ALU ops and load base; RET reads it
    // only when the return target comes from the link register instead of the RAS.
    function automatic logic op_reads_rs1(input logic [3:0] op, input logic ras_en);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADD) || (op == OP_LW) ||
               ((op == OP_RET) && !ras_en);
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// fetch_redirect_ctrl_if: bundle between the IF/ID register, the EX hazard source and
// the fetch stage redirect inputs.
//   master: the redirect controller (reads ID/EX state, drives redirect + RAS status)
//   slave : the surrounding pipeline (drives ID/EX state, consumes redirect)
interface fetch_redirect_ctrl_if #(
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

    logic [15:0]     id_instr;
    logic [15:0]     id_npc;
    logic [15:0]     rd_val;
    logic [15:0]     rs1_val;
    logic            ex_is_load;
    logic [2:0]      ex_rd;

    logic [1:0]      pc_src;
    logic [15:0]     j_type_imm;
    logic [15:0]     i_type_imm;
    logic [15:0]     return_address;
    logic            stall;
    logic            kill;
    logic [CntW-1:0] ras_count;
    logic            ras_overflow;
    logic            ras_underflow;

    modport master (
        input  id_instr, id_npc, rd_val, rs1_val, ex_is_load, ex_rd,
        output pc_src, j_type_imm, i_type_imm, return_address, stall, kill,
               ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        output id_instr, id_npc, rd_val, rs1_val, ex_is_load, ex_rd,
        input  pc_src, j_type_imm, i_type_imm, return_address, stall, kill,
               ras_count, ras_overflow, ras_underflow
    );

endinterface

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack.
//   clk, reset   : clock, asynchronous active-high reset (empties stack, clears flags)
//   push_i       : push push_data_i; when full the oldest entry is overwritten
//   pop_i        : pop the top entry; when empty nothing moves and underflow is flagged
//   top_o        : current top of stack, 0 when empty
//   count_o      : number of valid entries (saturates at RAS_DEPTH)
//   overflow_o   : sticky, push while full
//   underflow_o  : sticky, pop while empty
module return_addr_stack #(
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [15:0]                  push_data_i,
    output logic [15:0]                  top_o,
    output logic [$clog2(RAS_DEPTH):0]   count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [15:0]     mem_q [RAS_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            full, empty;

    assign full  = (count_q == CntW'(RAS_DEPTH));
    assign empty = (count_q == '0);

    // wptr_q is the next write slot; with a full stack it also points at the
    // oldest entry, so a wrapping push overwrites exactly that one.
    always_comb begin
        wptr_d  = wptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push_i) begin
            wptr_d = wptr_q + PtrW'(1);
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end else if (pop_i) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                wptr_d  = wptr_q - PtrW'(1);
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage needs no reset: count_q masks stale entries.
    always_ff @(posedge clk) begin
        if (push_i && !reset) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign top_o       = empty ? 16'h0000 : mem_q[wptr_q - PtrW'(1)];
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: ID-stage control-flow resolution driving the fetch redirect.
//   clk, reset : clock, asynchronous active-high reset
//   frc        : fetch_redirect_ctrl_if.master
//                in : id_instr, id_npc, rd_val, rs1_val, ex_is_load, ex_rd
//                out: pc_src, j_type_imm, i_type_imm, return_address, stall, kill,
//                     ras_count, ras_overflow, ras_underflow
// Build option: define FRC_RAS_EN to build the return-address stack. Without it RET
// jumps to rs1_val (link register), CALL pushes nothing and the RAS status reads 0.
module fetch_redirect_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    fetch_redirect_ctrl_if.master   frc
);
`ifdef FRC_RAS_EN
    localparam logic RasEn = 1'b1;
`else
    localparam logic RasEn = 1'b0;
`endif

    logic [3:0] opcode;
    logic [2:0] rd_f;
    logic [2:0] rs1_f;
    logic [5:0] imm6;
    logic [11:0] off12;
    logic       hazard;
    logic       stall_d, stall_q;
    pc_src_e    pc_sel;

    assign opcode = frc.id_instr[15:12];
    assign rd_f   = frc.id_instr[11:9];
    assign rs1_f  = frc.id_instr[8:6];
    assign imm6   = frc.id_instr[5:0];
    assign off12  = frc.id_instr[11:0];

    assign frc.j_type_imm = {frc.id_npc[15:12], off12};
    assign frc.i_type_imm = frc.id_npc + {{10{imm6[5]}}, imm6};

    assign hazard = frc.ex_is_load &&
                    ((op_reads_rd(opcode) && (frc.ex_rd == rd_f)) ||
                     (op_reads_rs1(opcode, RasEn) && (frc.ex_rd == rs1_f)));

    // stall_q blocks a second stall on the same hazard: the load has moved on.
    assign stall_d = !reset && !stall_q && hazard;

    always_comb begin
        pc_sel = PCSRC_SEQ;
        case (opcode)
            OP_JMP:  pc_sel = PCSRC_J;
            OP_CALL: pc_sel = PCSRC_J;
            OP_RET:  pc_sel = PCSRC_RET;
            OP_BEQ:  if (frc.rd_val == frc.rs1_val) pc_sel = PCSRC_I;
            OP_BNE:  if (frc.rd_val != frc.rs1_val) pc_sel = PCSRC_I;
            default: pc_sel = PCSRC_SEQ;
        endcase
        // A stalled instruction is re-presented next cycle and acts then.
        if (stall_d || reset) begin
            pc_sel = PCSRC_SEQ;
        end
    end

    assign frc.pc_src = pc_sel;
    assign frc.kill   = (pc_sel != PCSRC_SEQ);
    assign frc.stall  = stall_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end

`ifdef FRC_RAS_EN
    logic        ras_push;
    logic        ras_pop;
    logic [15:0] ras_top;

    assign ras_push = (opcode == OP_CALL) && !stall_d && !reset;
    assign ras_pop  = (opcode == OP_RET) && !stall_d && !reset;

    return_addr_stack #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (frc.id_npc),
        .top_o       (ras_top),
        .count_o     (frc.ras_count),
        .overflow_o  (frc.ras_overflow),
        .underflow_o (frc.ras_underflow)
    );

    assign frc.return_address = ras_top;
`else
    localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

    assign frc.return_address = reset ? 16'h0000 : frc.rs1_val;
    assign frc.ras_count      = {CntW{1'b0}};
    assign frc.ras_overflow   = 1'b0;
    assign frc.ras_underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;
    localparam int unsigned DEPTH = 4;
`ifdef FRC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_redirect_ctrl_if #(.RAS_DEPTH(DEPTH)) bus ();

    fetch_redirect_ctrl #(.RAS_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .frc   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_stack[$];
    bit          m_ovf, m_unf, m_stalled;

    function automatic logic [15:0] exp_ret_of(input logic [15:0] ras_v, input logic [15:0] rs1);
        return RAS_EN ? ras_v : rs1;
    endfunction

    function automatic int exp_cnt_of(input int n);
        return RAS_EN ? n : 0;
    endfunction

    // Which register fields an opcode reads, straight from the ISA description.
    function automatic bit model_hazard(input logic [15:0] ins, input bit ld, input logic [2:0] exrd);
        logic [3:0] op;
        bit rd_src, rs_src;
        op = ins[15:12];
        rd_src = (op == 4'h9) || (op == 4'hA);
        rs_src = rd_src || (op == 4'h0) || (op == 4'h6) || ((op == 4'hE) && !RAS_EN);
        return ld && ((rd_src && exrd == ins[11:9]) || (rs_src && exrd == ins[8:6]));
    endfunction

    task automatic drive(input logic [15:0] ins, input logic [15:0] npc, input logic [15:0] rdv,
                         input logic [15:0] rsv, input bit ld, input logic [2:0] exrd);
        @(negedge clk);
        bus.id_instr   = ins;
        bus.id_npc     = npc;
        bus.rd_val     = rdv;
        bus.rs1_val    = rsv;
        bus.ex_is_load = ld;
        bus.ex_rd      = exrd;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.id_instr = 16'h9280; bus.id_npc = 16'h1234; bus.rd_val = 16'd3;
        bus.rs1_val = 16'd3; bus.ex_is_load = 1'b1; bus.ex_rd = 3'd2;
        #1;
        checks++; if (bus.pc_src !== 2'd0) begin errors++; $display("FAIL rst_pc_src got %0d exp 0", bus.pc_src); end
        checks++; if (bus.kill !== 1'b0) begin errors++; $display("FAIL rst_kill got %b exp 0", bus.kill); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.stall); end
        checks++; if (bus.ras_count !== '0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.ras_count); end
        checks++; if (bus.return_address !== 16'h0) begin errors++; $display("FAIL rst_ret got %h exp 0000", bus.return_address); end
        checks++; if (bus.j_type_imm !== 16'h1280) begin errors++; $display("FAIL rst_jimm got %h exp 1280", bus.j_type_imm); end
        checks++; if ({bus.ras_overflow, bus.ras_underflow} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {bus.ras_overflow, bus.ras_underflow}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.ex_is_load = 1'b0;
    endtask

    task automatic test_jmp();
        drive(16'hC020, 16'h3005, 16'h0, 16'h0, 1'b0, 3'd0);
        checks++; if (bus.pc_src !== 2'd1) begin errors++; $display("FAIL jmp_pc_src got %0d exp 1", bus.pc_src); end
        checks++; if (bus.j_type_imm !== 16'h3020) begin errors++; $display("FAIL jmp_target got %h exp 3020", bus.j_type_imm); end
        checks++; if (bus.kill !== 1'b1) begin errors++; $display("FAIL jmp_kill got %b exp 1", bus.kill); end
        drive(16'h0240, 16'h3021, 16'h0, 16'h0, 1'b0, 3'd0);
        checks++; if (bus.kill !== 1'b0) begin errors++; $display("FAIL jmp_kill_after got %b exp 0", bus.kill); end
    endtask

    task automatic test_branch();
        drive(16'h92BE, 16'h0010, 16'd5, 16'd5, 1'b0, 3'd0);
        checks++; if (bus.pc_src !== 2'd2) begin errors++; $display("FAIL beq_taken_pc got %0d exp 2", bus.pc_src); end
        checks++; if (bus.i_type_imm !== 16'h000E) begin errors++; $display("FAIL beq_target got %h exp 000e", bus.i_type_imm); end
        checks++; if (bus.kill !== 1'b1) begin errors++; $display("FAIL beq_kill got %b exp 1", bus.kill); end
        drive(16'h92BE, 16'h0010, 16'd6, 16'd5, 1'b0, 3'd0);
        checks++; if (bus.pc_src !== 2'd0) begin errors++; $display("FAIL beq_nt_pc got %0d exp 0", bus.pc_src); end
        checks++; if (bus.kill !== 1'b0) begin errors++; $display("FAIL beq_nt_kill got %b exp 0", bus.kill); end
        drive(16'hA2BE, 16'h0010, 16'd6, 16'd5, 1'b0, 3'd0);
        checks++; if (bus.pc_src !== 2'd2) begin errors++; $display("FAIL bne_taken_pc got %0d exp 2", bus.pc_src); end
    endtask

    task automatic test_load_use();
        // BEQ R1, R2 with load to R2 in EX
        drive(16'h9285, 16'h0100, 16'd7, 16'd7, 1'b1, 3'd2);
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", bus.stall); end
        checks++; if (bus.pc_src !== 2'd0) begin errors++; $display("FAIL lu_pc_hold got %0d exp 0", bus.pc_src); end
        checks++; if (bus.kill !== 1'b0) begin errors++; $display("FAIL lu_kill_hold got %b exp 0", bus.kill); end
        drive(16'h9285, 16'h0100, 16'd7, 16'd7, 1'b1, 3'd2);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_stall2 got %b exp 0", bus.stall); end
        checks++; if (bus.pc_src !== 2'd2) begin errors++; $display("FAIL lu_resolve got %0d exp 2", bus.pc_src); end
        checks++; if (bus.i_type_imm !== 16'h0105) begin errors++; $display("FAIL lu_target got %h exp 0105", bus.i_type_imm); end
        drive(16'h0000, 16'h0101, 16'd0, 16'd0, 1'b0, 3'd0);
    endtask

    task automatic test_call_ret();
        drive(16'hD123, 16'h0041, 16'h0, 16'h0, 1'b0, 3'd0);
        checks++; if (bus.pc_src !== 2'd1) begin errors++; $display("FAIL call_pc got %0d exp 1", bus.pc_src); end
        drive(16'hE000, 16'h0124, 16'h0, 16'h1234, 1'b0, 3'd0);
        checks++; if (bus.ras_count !== 3'(exp_cnt_of(1))) begin errors++; $display("FAIL call_count got %0d exp %0d", bus.ras_count, exp_cnt_of(1)); end
        checks++; if (bus.pc_src !== 2'd3) begin errors++; $display("FAIL ret_pc got %0d exp 3", bus.pc_src); end
        checks++; if (bus.return_address !== exp_ret_of(16'h0041, 16'h1234)) begin errors++; $display("FAIL ret_addr got %h exp %h", bus.return_address, exp_ret_of(16'h0041, 16'h1234)); end
        drive(16'h0000, 16'h0042, 16'h0, 16'h0, 1'b0, 3'd0);
        checks++; if (bus.ras_count !== '0) begin errors++; $display("FAIL ret_count got %0d exp 0", bus.ras_count); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_r;
        for (int i = 0; i < 5; i++) drive(16'hD000, 16'h0100 + 16'(i), 16'h0, 16'h0, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            drive(16'hE000, 16'h0200, 16'h0, 16'h0BAD, 1'b0, 3'd0);
            if (i == 0) begin
                checks++; if (bus.ras_count !== 3'(exp_cnt_of(4))) begin errors++; $display("FAIL ovf_count got %0d exp %0d", bus.ras_count, exp_cnt_of(4)); end
                checks++; if (bus.ras_overflow !== RAS_EN) begin errors++; $display("FAIL ovf_flag got %b exp %b", bus.ras_overflow, RAS_EN); end
            end
            exp_r = (i < 4) ? 16'h0104 - 16'(i) : 16'h0000;
            checks++; if (bus.return_address !== exp_retOF(exp_r)) begin errors++; $display("FAIL lifo_ret%0d got %h exp %h", i, bus.return_address, exp_retOF(exp_r)); end
        end
        drive(16'h0000, 16'h0201, 16'h0, 16'h0, 1'b0, 3'd0);
        checks++; if (bus.ras_underflow !== RAS_EN) begin errors++; $display("FAIL unf_flag got %b exp %b", bus.ras_underflow, RAS_EN); end
        checks++; if (bus.ras_count !== '0) begin errors++; $display("FAIL unf_count got %0d exp 0", bus.ras_count); end
    endtask

    function automatic logic [15:0] exp_retOF(input logic [15:0] v);
        return exp_ret_of(v, 16'h0BAD);
    endfunction

    task automatic test_reset_mid();
        drive(16'hD000, 16'h0041, 16'h0, 16'h0, 1'b0, 3'd0);
        drive(16'hE000, 16'h0050, 16'h0, 16'h0777, 1'b1, 3'd0);
        checks++; if (bus.ras_count !== 3'(exp_cnt_of(1))) begin errors++; $display("FAIL mid_pre_count got %0d exp %0d", bus.ras_count, exp_cnt_of(1)); end
        reset = 1'b1;
        #1;
        checks++; if (bus.ras_count !== '0) begin errors++; $display("FAIL mid_count got %0d exp 0", bus.ras_count); end
        checks++; if (bus.pc_src !== 2'd0) begin errors++; $display("FAIL mid_pc got %0d exp 0", bus.pc_src); end
        checks++; if (bus.kill !== 1'b0) begin errors++; $display("FAIL mid_kill got %b exp 0", bus.kill); end
        checks++; if (bus.return_address !== 16'h0) begin errors++; $display("FAIL mid_ret got %h exp 0000", bus.return_address); end
        checks++; if ({bus.ras_overflow, bus.ras_underflow} !== 2'b00) begin errors++; $display("FAIL mid_flags got %b exp 00", {bus.ras_overflow, bus.ras_underflow}); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.ex_is_load = 1'b0;
        m_stack.delete();
        m_ovf = 0; m_unf = 0; m_stalled = 0;
    endtask

    task automatic test_random();
        logic [3:0]  ops [8];
        logic [15:0] ins, npc, rdv, rsv, e_ret, e_i;
        logic [2:0]  exrd;
        logic [1:0]  e_pc;
        bit          ld, e_st, push, pop;
        ops = '{4'hC, 4'hD, 4'hE, 4'h9, 4'hA, 4'h6, 4'h0, 4'h3};
        for (int n = 0; n < 400; n++) begin
            ins = 16'($urandom);
            ins[15:12] = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) ins[15:12] = 4'($urandom);
            npc  = 16'($urandom);
            rdv  = 16'($urandom_range(0, 2));
            rsv  = 16'($urandom_range(0, 2));
            ld   = ($urandom_range(0, 2) == 0);
            exrd = 3'($urandom);
            drive(ins, npc, rdv, rsv, ld, exrd);
            // model
            e_st = !m_stalled && model_hazard(ins, ld, exrd);
            e_pc = 2'd0; push = 0; pop = 0;
            if (!e_st) begin
                case (ins[15:12])
                    4'hC: e_pc = 2'd1;
                    4'hD: begin e_pc = 2'd1; push = RAS_EN; end
                    4'hE: begin e_pc = 2'd3; pop = RAS_EN; end
                    4'h9: e_pc = (rdv == rsv) ? 2'd2 : 2'd0;
                    4'hA: e_pc = (rdv != rsv) ? 2'd2 : 2'd0;
                    default: e_pc = 2'd0;
                endcase
            end
            e_ret = RAS_EN ? ((m_stack.size() > 0) ? m_stack[$] : 16'h0) : rsv;
            e_i   = 16'(int'(npc) + int'($signed(ins[5:0])));
            checks++; if (bus.pc_src !== e_pc) begin errors++; $display("FAIL rnd%0d_pc got %0d exp %0d", n, bus.pc_src, e_pc); end
            checks++; if (bus.kill !== (e_pc != 0)) begin errors++; $display("FAIL rnd%0d_kill got %b exp %b", n, bus.kill, e_pc != 0); end
            checks++; if (bus.stall !== e_st) begin errors++; $display("FAIL rnd%0d_stall got %b exp %b", n, bus.stall, e_st); end
            checks++; if (bus.j_type_imm !== {npc[15:12], ins[11:0]}) begin errors++; $display("FAIL rnd%0d_jimm got %h exp %h", n, bus.j_type_imm, {npc[15:12], ins[11:0]}); end
            checks++; if (bus.i_type_imm !== e_i) begin errors++; $display("FAIL rnd%0d_iimm got %h exp %h", n, bus.i_type_imm, e_i); end
            checks++; if (bus.return_address !== e_ret) begin errors++; $display("FAIL rnd%0d_ret got %h exp %h", n, bus.return_address, e_ret); end
            checks++; if (bus.ras_count !== 3'(m_stack.size())) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", n, bus.ras_count, m_stack.size()); end
            checks++; if ({bus.ras_overflow, bus.ras_underflow} !== {m_ovf, m_unf}) begin errors++; $display("FAIL rnd%0d_flags got %b exp %b", n, {bus.ras_overflow, bus.ras_underflow}, {m_ovf, m_unf}); end
            // commit at the coming edge
            if (push) begin
                if (m_stack.size() == DEPTH) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1;
                end
                m_stack.push_back(npc);
            end
            if (pop) begin
                if (m_stack.size() == 0) m_unf = 1;
                else void'(m_stack.pop_back());
            end
            m_stalled = e_st;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_jmp();
        test_branch();
        test_load_use();
        test_call_ret();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
